// File: rtl/aska_pkg.sv
// Shared constants for the ASKA SPI register file: register map, field layout and FSM states.
package aska_pkg;

    localparam int NUM_REGS_DEF = 4;
    localparam int AMP_MAX_DEF  = 50;
    localparam int FREQ_MIN_DEF = 400;

    localparam logic [1:0] ADDR_CONF0 = 2'd0;
    localparam logic [1:0] ADDR_CONF1 = 2'd1;
    localparam logic [1:0] ADDR_ELE1  = 2'd2;
    localparam logic [1:0] ADDR_ELE2  = 2'd3;

    // conf0 layout
    localparam int FREQ_LSB = 0;
    localparam int FREQ_W   = 12;
    localparam int AMP_LSB  = 12;
    localparam int AMP_W    = 6;
    localparam int RAMP_LSB = 18;
    localparam int RAMP_W   = 6;
    localparam int ON_LSB   = 24;
    localparam int ON_W     = 8;

    // conf1 layout; bits [31:24] are stored but carry no field
    localparam int RF_LSB   = 0;
    localparam int RF_W     = 10;
    localparam int OFF_LSB  = 10;
    localparam int OFF_W    = 10;
    localparam int EN_BIT   = 20;
    localparam int PH_LSB   = 21;
    localparam int PH_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_COMMIT,
        ST_DISCARD
    } state_t;

endpackage

// File: rtl/aska_sync2.sv
// Two-flop synchroniser; resets to 1 so an idle (deasserted) chip select is assumed.
module aska_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aska_spi_regfile.sv
// Assembles 5-byte SPI frames (address + 32-bit MSB-first data) into four config registers
// and decodes them into the stimulation generator's fields.
module aska_spi_regfile
    import aska_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int AMP_MAX  = AMP_MAX_DEF,
    parameter int FREQ_MIN = FREQ_MIN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic [5:0]  amplitude,
    output logic [11:0] freq,
    output logic [5:0]  ramp,
    output logic [7:0]  on_time,
    output logic [9:0]  ramp_factor,
    output logic [9:0]  off_time,
    output logic        stim_enable,
    output logic [2:0]  phase_dur,
    output logic [31:0] electrode1,
    output logic [31:0] electrode2,
    output logic        cfg_update,
    output logic [7:0]  frame_err_cnt
);

    state_t      state;
    logic        cs_sync;
    logic        cs_prev;
    logic        cs_fall;
    logic        cs_rise;
    logic [1:0]  addr_q;
    logic [1:0]  byte_cnt;
    logic [31:0] shift_q;
    logic        upd_pend;
    logic [31:0] conf0;
    logic [31:0] conf1;
    logic [31:0] ele1;
    logic [31:0] ele2;

    aska_sync2 u_cs_sync (
        .clk (clk),
        .rst (rst),
        .d   (spi_cs_n),
        .q   (cs_sync)
    );

    assign cs_fall = cs_prev & ~cs_sync;
    assign cs_rise = ~cs_prev & cs_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cs_prev       <= 1'b1;
            addr_q        <= '0;
            byte_cnt      <= '0;
            shift_q       <= '0;
            upd_pend      <= 1'b0;
            cfg_update    <= 1'b0;
            frame_err_cnt <= '0;
            conf0         <= '0;
            conf1         <= '0;
            ele1          <= '0;
            ele2          <= '0;
        end else begin
            cs_prev    <= cs_sync;
            upd_pend   <= 1'b0;
            cfg_update <= upd_pend;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) state <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                    end else if (rx_valid) begin
                        if (int'(rx_byte) < NUM_REGS) begin
                            addr_q   <= rx_byte[1:0];
                            byte_cnt <= '0;
                            state    <= ST_DATA;
                        end else begin
                            if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
                            state <= ST_DISCARD;
                        end
                    end
                end
                ST_DATA: begin
                    // A final byte arriving with the CS rise still completes the frame.
                    if (rx_valid && byte_cnt == 2'd3) begin
                        shift_q <= {shift_q[23:0], rx_byte};
                        state   <= ST_COMMIT;
                    end else if (cs_rise) begin
                        if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
                        state <= ST_IDLE;
                    end else if (rx_valid) begin
                        shift_q  <= {shift_q[23:0], rx_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                ST_COMMIT: begin
                    case (addr_q)
                        ADDR_CONF0: conf0 <= shift_q;
                        ADDR_CONF1: conf1 <= shift_q;
                        ADDR_ELE1:  ele1  <= shift_q;
                        ADDR_ELE2:  ele2  <= shift_q;
                    endcase
                    upd_pend <= 1'b1;
                    state    <= ST_DISCARD;
                end
                ST_DISCARD: begin
                    if (cs_sync) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [AMP_W-1:0]  amp_raw;
    logic [FREQ_W-1:0] freq_raw;
    logic              unused_conf1_hi;

    assign amp_raw  = conf0[AMP_LSB +: AMP_W];
    assign freq_raw = conf0[FREQ_LSB +: FREQ_W];

    assign amplitude   = (amp_raw > AMP_W'(AMP_MAX)) ? AMP_W'(AMP_MAX) : amp_raw;
    assign freq        = (freq_raw < FREQ_W'(FREQ_MIN)) ? FREQ_W'(FREQ_MIN) : freq_raw;
    assign ramp        = conf0[RAMP_LSB +: RAMP_W];
    assign on_time     = conf0[ON_LSB +: ON_W];
    assign ramp_factor = conf1[RF_LSB +: RF_W];
    assign off_time    = conf1[OFF_LSB +: OFF_W];
    assign stim_enable = conf1[EN_BIT];
    assign phase_dur   = conf1[PH_LSB +: PH_W];
    assign electrode1  = ele1;
    assign electrode2  = ele2;

    assign unused_conf1_hi = &{1'b0, conf1[31:24]};

endmodule
